// File: rtl/laser_point_feeder_pkg.sv
// laser_pkg: shared types and defaults for the LASER point feeder.
//   state_t  - feeder FSM states
//   point_t  - one (x,y) frame point as stored in frame RAM
//   *_DEF    - default values for the top-level parameters
package laser_pkg;

    localparam int COORD_W         = 4;
    localparam int NUM_POINTS_DEF  = 40;
    localparam int RADIUS_SQ_DEF   = 16;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int COVER_W_DEF     = $clog2(NUM_POINTS_DEF + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND   = 3'd1,
        WAIT   = 3'd2,
        SCORE  = 3'd3,
        REPORT = 3'd4
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

endpackage

// File: rtl/laser_cover_check.sv
// laser_cover_check: combinational "is point inside circle" test.
//   px, py   in  point coordinates
//   cx, cy   in  circle centre
//   covered  out 1 when dx*dx + dy*dy <= RADIUS_SQ
module laser_cover_check
    import laser_pkg::*;
#(
    parameter int RADIUS_SQ = RADIUS_SQ_DEF
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic               covered
);

    localparam int SQ_W = 2 * COORD_W;

    logic [COORD_W:0]   dx, dy;     // signed difference, one extra bit
    logic [COORD_W:0]   ndx, ndy;
    logic [COORD_W-1:0] adx, ady;   // magnitudes always fit COORD_W bits
    logic [SQ_W-1:0]    sqx, sqy;
    logic [SQ_W:0]      sum;

    assign dx  = {1'b0, px} - {1'b0, cx};
    assign dy  = {1'b0, py} - {1'b0, cy};
    assign ndx = -dx;
    assign ndy = -dy;
    assign adx = dx[COORD_W] ? ndx[COORD_W-1:0] : dx[COORD_W-1:0];
    assign ady = dy[COORD_W] ? ndy[COORD_W-1:0] : dy[COORD_W-1:0];

    assign sqx = {{COORD_W{1'b0}}, adx} * {{COORD_W{1'b0}}, adx};
    assign sqy = {{COORD_W{1'b0}}, ady} * {{COORD_W{1'b0}}, ady};
    assign sum = {1'b0, sqx} + {1'b0, sqy};

    assign covered = (sum <= (SQ_W+1)'(RADIUS_SQ));

endmodule

// File: rtl/laser_point_feeder.sv
// laser_point_feeder: host-side transmitter for the LASER point-cover engine.
// Holds one frame in RAM, streams it on X/Y, waits for DONE, captures the two
// circle centres, re-scores them against the frame and reports the count.
//   CLK, RST                 clock, synchronous active-high reset
//   wr_en/wr_addr/wr_x/wr_y  frame RAM write port (IDLE only)
//   start                    send-frame pulse (IDLE only)
//   X, Y                     point stream to engine (0 outside SEND)
//   C1X,C1Y,C2X,C2Y, DONE    engine result and its valid pulse
//   busy                     SEND/WAIT/SCORE
//   result_valid             one-cycle pulse in REPORT
//   res_c1x..res_c2y         captured centres, res_cover covered-point count
//   timeout                  DONE watchdog fired for this frame
// Optional build macro LASER_FEEDER_TIMEOUT_EN adds the WAIT watchdog
// (TIMEOUT_CYC cycles); without it WAIT is unbounded and timeout is 0.
module laser_point_feeder
    import laser_pkg::*;
#(
    parameter int NUM_POINTS  = NUM_POINTS_DEF,
    parameter int RADIUS_SQ   = RADIUS_SQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int ADDR_W      = $clog2(NUM_POINTS),
    parameter int COVER_W     = $clog2(NUM_POINTS + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               start,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic [COORD_W-1:0] C1X,
    input  logic [COORD_W-1:0] C1Y,
    input  logic [COORD_W-1:0] C2X,
    input  logic [COORD_W-1:0] C2Y,
    input  logic               DONE,
    output logic               busy,
    output logic               result_valid,
    output logic [COORD_W-1:0] res_c1x,
    output logic [COORD_W-1:0] res_c1y,
    output logic [COORD_W-1:0] res_c2x,
    output logic [COORD_W-1:0] res_c2y,
    output logic [COVER_W-1:0] res_cover,
    output logic               timeout
);

    localparam logic [ADDR_W:0]   NP_EXT   = (ADDR_W+1)'(NUM_POINTS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_POINTS - 1);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  idx;
    logic               idx_last;
    logic [COVER_W-1:0] cnt;
    point_t             ram [NUM_POINTS];
    point_t             pt;
    logic               cov1, cov2, hit;
    logic               wait_expire;

    assign idx_last = (idx == LAST_IDX);
    assign pt       = ram[idx];

    // Frame RAM: not reset; writable only in IDLE. A write in the same cycle
    // as start lands before SEND reads it, so the new value is sent.
    always_ff @(posedge CLK) begin
        if (state == IDLE && wr_en && ({1'b0, wr_addr} < NP_EXT))
            ram[wr_addr] <= '{x: wr_x, y: wr_y};
    end

`ifdef LASER_FEEDER_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCNT_W-1:0] wait_cnt;
    logic              timeout_q;

    // Counts cycles spent in WAIT; 0 on the first WAIT cycle.
    always_ff @(posedge CLK) begin
        if (RST || state != WAIT) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + 1'b1;
    end

    assign wait_expire = (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1));
    assign timeout     = timeout_q;
`else
    assign wait_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)       state_nx = SEND;
            SEND:    if (idx_last)    state_nx = WAIT;
            WAIT:    if (DONE)        state_nx = SCORE;
                     else if (wait_expire) state_nx = REPORT;
            SCORE:   if (idx_last)    state_nx = REPORT;
            REPORT:                   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        X            = '0;
        Y            = '0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            SEND: begin
                X    = pt.x;
                Y    = pt.y;
                busy = 1'b1;
            end
            WAIT, SCORE: busy = 1'b1;
            REPORT:      result_valid = 1'b1;
            default: ;
        endcase
    end

    laser_cover_check #(.RADIUS_SQ(RADIUS_SQ)) u_cov1 (
        .px(pt.x), .py(pt.y), .cx(res_c1x), .cy(res_c1y), .covered(cov1)
    );
    laser_cover_check #(.RADIUS_SQ(RADIUS_SQ)) u_cov2 (
        .px(pt.x), .py(pt.y), .cx(res_c2x), .cy(res_c2y), .covered(cov2)
    );

    // A point inside both circles counts once.
    assign hit = cov1 | cov2;

    // Index, running count and captured results
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx       <= '0;
            cnt       <= '0;
            res_c1x   <= '0;
            res_c1y   <= '0;
            res_c2x   <= '0;
            res_c2y   <= '0;
            res_cover <= '0;
`ifdef LASER_FEEDER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
`ifdef LASER_FEEDER_TIMEOUT_EN
                    if (start) timeout_q <= 1'b0;
`endif
                end
                SEND: idx <= idx_last ? '0 : idx + 1'b1;
                WAIT: begin
                    idx <= '0;
                    cnt <= '0;   // count starts clean on SCORE entry
                    if (DONE) begin
                        res_c1x <= C1X;
                        res_c1y <= C1Y;
                        res_c2x <= C2X;
                        res_c2y <= C2Y;
                    end
`ifdef LASER_FEEDER_TIMEOUT_EN
                    else if (wait_expire) begin
                        res_c1x   <= '0;
                        res_c1y   <= '0;
                        res_c2x   <= '0;
                        res_c2y   <= '0;
                        res_cover <= '0;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                SCORE: begin
                    idx <= idx_last ? '0 : idx + 1'b1;
                    cnt <= cnt + COVER_W'(hit);
                    if (idx_last) res_cover <= cnt + COVER_W'(hit);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_point_feeder.sv
module tb_laser_point_feeder;

    localparam int NP = 40;
`ifdef LASER_FEEDER_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    logic       CLK = 0;
    logic       RST = 1;
    logic       wr_en = 0;
    logic [5:0] wr_addr = 0;
    logic [3:0] wr_x = 0, wr_y = 0;
    logic       start = 0;
    logic [3:0] X, Y;
    logic [3:0] C1X = 0, C1Y = 0, C2X = 0, C2Y = 0;
    logic       DONE = 0;
    logic       busy, result_valid, timeout;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic [5:0] res_cover;

    laser_point_feeder #(.NUM_POINTS(NP), .RADIUS_SQ(16), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
        .start(start), .X(X), .Y(Y), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .DONE(DONE), .busy(busy), .result_valid(result_valid),
        .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
        .res_cover(res_cover), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NP-1:0][3:0] px;
        logic [NP-1:0][3:0] py;
        logic [3:0]         c1x, c1y, c2x, c2y;
        int                 exp_cover;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Writes every point; the last write shares its cycle with start.
    task automatic load_and_start(input int i);
        for (int k = 0; k < NP; k++) begin
            wr_en   = 1;
            wr_addr = 6'(k);
            wr_x    = vecs[i].px[k];
            wr_y    = vecs[i].py[k];
            start   = (k == NP - 1);
            tick();
        end
        wr_en = 0;
        start = 0;
    endtask

    task automatic start_only();
        start = 1;
        tick();
        start = 0;
    endtask

    // Called in the first SEND cycle; leaves the bench in the first WAIT cycle.
    task automatic check_send(input int i, input int done_at);
        for (int k = 0; k < NP; k++) begin
            DONE = (k == done_at);
            if (k == done_at) begin
                C1X = 4'hF; C1Y = 4'hF; C2X = 4'hF; C2Y = 4'hF;
            end
            chk($sformatf("send_x[%0d]", k), X, vecs[i].px[k]);
            chk($sformatf("send_y[%0d]", k), Y, vecs[i].py[k]);
            chk($sformatf("send_busy[%0d]", k), busy, 1);
            tick();
        end
        DONE = 0;
        chk("wait_x_zero", X, 0);
        chk("wait_y_zero", Y, 0);
        chk("wait_busy", busy, 1);
    endtask

    // Spends nwait idle WAIT cycles, then pulses DONE with the vector's centres.
    task automatic done_phase(input int i, input int nwait, input bit start_in_wait);
        for (int w = 0; w < nwait; w++) begin
            start = start_in_wait && (w == 1);
            tick();
        end
        start = 0;
        C1X = vecs[i].c1x; C1Y = vecs[i].c1y; C2X = vecs[i].c2x; C2Y = vecs[i].c2y;
        DONE = 1;
        tick();
        DONE = 0;
        C1X = ~vecs[i].c1x; C1Y = ~vecs[i].c1y; C2X = ~vecs[i].c2x; C2Y = ~vecs[i].c2y;
    endtask

    // Called in the first SCORE cycle.
    task automatic await_result(input int i, input bit wr_in_score);
        int cyc = 0;
        while (!result_valid && cyc < 200) begin
            wr_en   = wr_in_score && (cyc == 5);
            wr_addr = 0; wr_x = 4'd9; wr_y = 4'd9;
            tick();
            cyc++;
        end
        wr_en = 0;
        chk("score_cycles", cyc, NP);
        chk("result_valid", result_valid, 1);
        chk("res_cover", res_cover, vecs[i].exp_cover);
        chk("res_c1x", res_c1x, vecs[i].c1x);
        chk("res_c1y", res_c1y, vecs[i].c1y);
        chk("res_c2x", res_c2x, vecs[i].c2x);
        chk("res_c2y", res_c2y, vecs[i].c2y);
        chk("report_busy", busy, 0);
        chk("report_timeout", timeout, 0);
        tick();
        chk("rv_one_cycle", result_valid, 0);
        chk("res_cover_held", res_cover, vecs[i].exp_cover);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        // ---- vector table ----
        for (int k = 0; k < NP; k++) begin
            vecs[0].px[k] = 4'd5;           vecs[0].py[k] = 4'd5;
            vecs[1].px[k] = 4'd15;          vecs[1].py[k] = 4'd15;
            vecs[2].px[k] = 4'(k % 16);     vecs[2].py[k] = 4'(k / 16);
            vecs[3].px[k] = 4'd15;          vecs[3].py[k] = 4'd15;
            vecs[4].px[k] = 4'd0;           vecs[4].py[k] = 4'd0;
            vecs[5].px[k] = 4'd0;           vecs[5].py[k] = 4'd0;
            vecs[6].px[k] = 4'd7;           vecs[6].py[k] = 4'd7;
        end
        vecs[1].px[0] = 0; vecs[1].py[0] = 0;
        vecs[1].px[1] = 4; vecs[1].py[1] = 0;
        vecs[1].px[2] = 5; vecs[1].py[2] = 0;
        vecs[1].px[3] = 3; vecs[1].py[3] = 3;
        vecs[1].px[4] = 2; vecs[1].py[4] = 3;
        // all at centre of C1
        vecs[0].c1x = 5;  vecs[0].c1y = 5; vecs[0].c2x = 0;  vecs[0].c2y = 0; vecs[0].exp_cover = 40;
        // (0,0),(4,0),(2,3) in; (5,0),(3,3) out
        vecs[1].c1x = 0;  vecs[1].c1y = 0; vecs[1].c2x = 15; vecs[1].c2y = 0; vecs[1].exp_cover = 3;
        // grid: C1 covers 5+4+4, C2 covers 4+4 on rows 0/1
        vecs[2].c1x = 0;  vecs[2].c1y = 0; vecs[2].c2x = 15; vecs[2].c2y = 2; vecs[2].exp_cover = 21;
        // far corner, nothing covered
        vecs[3].c1x = 0;  vecs[3].c1y = 0; vecs[3].c2x = 0;  vecs[3].c2y = 0; vecs[3].exp_cover = 0;
        // C2 at distance exactly 4 (sum == 16), negative dy
        vecs[4].c1x = 15; vecs[4].c1y = 15; vecs[4].c2x = 0; vecs[4].c2y = 4; vecs[4].exp_cover = 40;
        // just outside: 25 and 18
        vecs[5].c1x = 0;  vecs[5].c1y = 5; vecs[5].c2x = 3;  vecs[5].c2y = 3; vecs[5].exp_cover = 0;
        // inside both circles, counted once
        vecs[6].c1x = 7;  vecs[6].c1y = 7; vecs[6].c2x = 8;  vecs[6].c2y = 8; vecs[6].exp_cover = 40;

        // ---- reset ----
        RST = 1;
        repeat (3) tick();
        RST = 0;
        chk("rst_x", X, 0);
        chk("rst_y", Y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cover", res_cover, 0);
        chk("rst_c1x", res_c1x, 0);
        chk("rst_c2y", res_c2y, 0);

        // ---- table-driven frames ----
        for (int i = 0; i < NV; i++) begin
            load_and_start(i);
            check_send(i, -1);
            done_phase(i, i % 4, 0);
            await_result(i, 0);
        end

        // ---- DONE in SEND, start in WAIT, wr_en in SCORE all ignored ----
        load_and_start(1);
        check_send(1, 10);
        done_phase(1, 4, 1);
        await_result(1, 1);
        chk("no_restart_busy", busy, 0);
        start_only();
        check_send(1, -1);          // point 0 still (0,0), not (9,9)
        done_phase(1, 2, 0);
        await_result(1, 0);

        // ---- reset mid-SEND at k=20 ----
        load_and_start(2);
        repeat (20) tick();
        chk("mid_send_x", X, vecs[2].px[20]);
        RST = 1;
        tick();
        RST = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_x", X, 0);
        chk("mid_rst_y", Y, 0);
        chk("mid_rst_cover", res_cover, 0);
        start_only();
        check_send(2, -1);
        done_phase(2, 1, 0);
        await_result(2, 0);

        // ---- DONE watchdog ----
        load_and_start(0);
        check_send(0, -1);
`ifdef LASER_FEEDER_TIMEOUT_EN
        begin
            int cyc = 0;
            while (!result_valid && cyc < 200) begin
                tick();
                cyc++;
            end
            chk("to_latency", cyc, 64);
            chk("to_rv", result_valid, 1);
            chk("to_flag", timeout, 1);
            chk("to_cover", res_cover, 0);
            chk("to_c1x", res_c1x, 0);
            chk("to_c2y", res_c2y, 0);
            tick();
            chk("to_flag_held", timeout, 1);
            start_only();
            chk("to_flag_clear", timeout, 0);
            check_send(0, -1);
            done_phase(0, 0, 0);
            await_result(0, 0);
        end
`else
        begin
            int drops = 0;
            for (int w = 0; w < 200; w++) begin
                if (!busy || result_valid) drops++;
                tick();
            end
            chk("no_watchdog_busy", drops, 0);
            chk("no_watchdog_timeout", timeout, 0);
            done_phase(0, 0, 0);
            await_result(0, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, 1 expected 0");
        $fatal(1);
    end

endmodule
